// File: rtl/gx4000_dma_pkg.sv
// Shared definitions for the GX4000 Plus sound DMA sequencer: FSM states,
// sound-list opcodes, CTRL bit positions and the CPU register map.
package gx4000_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_FETCH,
        ST_EXEC,
        ST_AYWR,
        ST_NEXT
    } state_e;

    // Sound-list opcodes, taken from word[15:12]
    localparam logic [3:0] OP_LOAD   = 4'h0;
    localparam logic [3:0] OP_PAUSE  = 4'h1;
    localparam logic [3:0] OP_REPEAT = 4'h2;
    localparam logic [3:0] OP_CTRL   = 4'h4;

    // CTRL word bit positions; all set bits act together
    localparam int CTRL_LOOP = 0;
    localparam int CTRL_INT  = 4;
    localparam int CTRL_STOP = 5;

    // Register page layout: each channel owns a 4-byte stride, DCSR is shared
    localparam int         CH_STRIDE   = 4;
    localparam logic [7:0] OFF_ADDR_LO = 8'h00;
    localparam logic [7:0] OFF_ADDR_HI = 8'h01;
    localparam logic [7:0] OFF_PRESC   = 8'h02;
    localparam logic [7:0] OFF_DCSR    = 8'h0F;

    // DCSR fields: enables in [2:0], write-1-to-clear irq in [6:4]
    localparam int DCSR_EN_LSB  = 0;
    localparam int DCSR_CLR_LSB = 4;

    // Sound-list pointers step by one 16-bit word and wrap at the top of memory
    function automatic logic [15:0] next_addr(input logic [15:0] a);
        return a + 16'd2;
    endfunction

endpackage

// File: rtl/gx4000_dma_chan.sv
// One sound DMA channel: list pointer, prescaler, pause/loop counters,
// enable and sticky irq. The top-level FSM tells it when to step a pause
// (chk_i) and when to execute the fetched word (exec_i).
module gx4000_dma_chan
    import gx4000_dma_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        wr_addr_lo_i,
    input  logic        wr_addr_hi_i,
    input  logic        wr_presc_i,
    input  logic        wr_enable_i,
    input  logic        enable_val_i,
    input  logic        irq_clr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        chk_i,
    input  logic        exec_i,
    input  logic [15:0] word_i,
    output logic        enable_o,
    output logic        paused_o,
    output logic [15:0] addr_o,
    output logic        irq_o
);

    logic [15:0] addr_q, addr_d;
    logic [7:0]  prescaler_q, prescaler_d;
    logic [7:0]  presc_cnt_q, presc_cnt_d;
    logic [11:0] pause_cnt_q, pause_cnt_d;
    logic [11:0] loop_cnt_q, loop_cnt_d;
    logic [15:0] loop_addr_q, loop_addr_d;
    logic        enable_q, enable_d;
    logic        irq_q, irq_d;

    // Next-state: pause stepping, instruction execution, then CPU writes on top
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned and no latch is inferred.
        addr_d      = addr_q;
        prescaler_d = prescaler_q;
        presc_cnt_d = presc_cnt_q;
        pause_cnt_d = pause_cnt_q;
        loop_cnt_d  = loop_cnt_q;
        loop_addr_d = loop_addr_q;
        enable_d    = enable_q;
        irq_d       = irq_q;

        // irq clear sits before execution so a same-cycle INT set wins
        if (irq_clr_i) irq_d = 1'b0;

        if (chk_i && enable_q && (pause_cnt_q != 12'd0)) begin
            if (presc_cnt_q == 8'd0) begin
                presc_cnt_d = prescaler_q;
                pause_cnt_d = pause_cnt_q - 12'd1;
            end else begin
                presc_cnt_d = presc_cnt_q - 8'd1;
            end
        end

        if (exec_i) begin
            addr_d = next_addr(addr_q);
            case (word_i[15:12])
                OP_PAUSE: begin
                    pause_cnt_d = word_i[11:0];
                    presc_cnt_d = prescaler_q;
                end
                OP_REPEAT: begin
                    loop_cnt_d  = word_i[11:0];
                    loop_addr_d = next_addr(addr_q);
                end
                OP_CTRL: begin
                    if (word_i[CTRL_LOOP] && (loop_cnt_q != 12'd0)) begin
                        loop_cnt_d = loop_cnt_q - 12'd1;
                        addr_d     = loop_addr_q;
                    end
                    if (word_i[CTRL_INT])  irq_d    = 1'b1;
                    if (word_i[CTRL_STOP]) enable_d = 1'b0;
                end
                default: ;
            endcase
        end

        // CPU writes come last so they override any FSM update of the same byte
        if (wr_addr_lo_i) addr_d[7:0]  = {cpu_data_i[7:1], 1'b0};
        if (wr_addr_hi_i) addr_d[15:8] = cpu_data_i;
        if (wr_presc_i)   prescaler_d  = cpu_data_i;
        if (wr_enable_i)  enable_d     = enable_val_i;
    end

    // Channel register file with synchronous active-low reset
    always_ff @(posedge clk_sys) begin
        // NOTE: the register file is small flops, not a RAM, so it is fully reset to give a known power-up state.
        if (!reset_n) begin
            addr_q      <= '0;
            prescaler_q <= '0;
            presc_cnt_q <= '0;
            pause_cnt_q <= '0;
            loop_cnt_q  <= '0;
            loop_addr_q <= '0;
            enable_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values, independent of statement order.
            addr_q      <= addr_d;
            prescaler_q <= prescaler_d;
            presc_cnt_q <= presc_cnt_d;
            pause_cnt_q <= pause_cnt_d;
            loop_cnt_q  <= loop_cnt_d;
            loop_addr_q <= loop_addr_d;
            enable_q    <= enable_d;
            irq_q       <= irq_d;
        end
    end

    assign enable_o = enable_q;
    assign paused_o = (pause_cnt_q != 12'd0);
    assign addr_o   = addr_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/gx4000_dma_sound_sequencer.sv
// GX4000 Plus sound DMA sequencer: once per scanline, walks channels 0,1,2,
// fetching one sound-list word per enabled channel over the shared memory
// port and issuing AY register writes over the shared PSG port.
module gx4000_dma_sound_sequencer
    import gx4000_dma_pkg::*;
#(
    parameter int         NUM_CH   = 3,
    parameter logic [7:0] REG_PAGE = 8'h6C
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        plus_mode,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wr,
    input  logic        hsync_tick,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic        ay_wr,
    output logic [3:0]  ay_reg,
    output logic [7:0]  ay_data,
    input  logic        ay_ack,
    output logic [2:0]  irq,
    output logic [7:0]  status
);

    state_e      state_q, state_d;
    logic [1:0]  ch_q, ch_d;
    logic [15:0] word_q, word_d;
    logic        pending_q, pending_d;
    logic        overrun_q, overrun_d;
    logic        mem_rd_q, mem_rd_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        ay_wr_q, ay_wr_d;
    logic [3:0]  ay_reg_q, ay_reg_d;
    logic [7:0]  ay_data_q, ay_data_d;

    logic [NUM_CH-1:0] en_w;
    logic [NUM_CH-1:0] paused_w;
    logic [NUM_CH-1:0] irq_w;
    logic [15:0]       addr_w [NUM_CH];

    logic       page_wr;
    logic [7:0] off;
    logic       dcsr_wr;

    assign page_wr = cpu_wr && (cpu_addr[15:8] == REG_PAGE);
    assign off     = cpu_addr[7:0];
    assign dcsr_wr = page_wr && (off == OFF_DCSR);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [7:0] BASE = 8'(i * CH_STRIDE);

        gx4000_dma_chan u_chan (
            .clk_sys      (clk_sys),
            .reset_n      (reset_n),
            .wr_addr_lo_i (page_wr && (off == BASE + OFF_ADDR_LO)),
            .wr_addr_hi_i (page_wr && (off == BASE + OFF_ADDR_HI)),
            .wr_presc_i   (page_wr && (off == BASE + OFF_PRESC)),
            .wr_enable_i  (dcsr_wr),
            .enable_val_i (cpu_data[DCSR_EN_LSB + i]),
            .irq_clr_i    (dcsr_wr && cpu_data[DCSR_CLR_LSB + i]),
            .cpu_data_i   (cpu_data),
            .chk_i        ((state_q == ST_CHK) && (ch_q == 2'(i))),
            .exec_i       ((state_q == ST_EXEC) && (ch_q == 2'(i))),
            .word_i       (word_q),
            .enable_o     (en_w[i]),
            .paused_o     (paused_w[i]),
            .addr_o       (addr_w[i]),
            .irq_o        (irq_w[i])
        );
    end

    // Round sequencer: next state, handshake outputs and tick bookkeeping
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        word_d     = word_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        ay_wr_d    = ay_wr_q;
        ay_reg_d   = ay_reg_q;
        ay_data_d  = ay_data_q;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    ch_d      = 2'd0;
                    state_d   = ST_CHK;
                end
            end
            ST_CHK: begin
                // Disabled and pausing channels spend their slot without a fetch
                if (!en_w[ch_q] || paused_w[ch_q]) begin
                    state_d = ST_NEXT;
                end else begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = addr_w[ch_q];
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    word_d   = mem_data;
                    mem_rd_d = 1'b0;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (word_q[15:12] == OP_LOAD) begin
                    ay_wr_d   = 1'b1;
                    ay_reg_d  = word_q[11:8];
                    ay_data_d = word_q[7:0];
                    state_d   = ST_AYWR;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_AYWR: begin
                if (ay_ack) begin
                    ay_wr_d = 1'b0;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (ch_q == 2'(NUM_CH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    state_d = ST_CHK;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new tick outranks the IDLE clear; a tick onto a still-pending one is an overrun
        if (hsync_tick && plus_mode) begin
            pending_d = 1'b1;
            if (pending_q) overrun_d = 1'b1;
        end
    end

    // Sequencer state and registered handshake outputs
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            word_q     <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            ay_wr_q    <= 1'b0;
            ay_reg_q   <= '0;
            ay_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            word_q     <= word_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            ay_wr_q    <= ay_wr_d;
            ay_reg_q   <= ay_reg_d;
            ay_data_q  <= ay_data_d;
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign ay_wr    = ay_wr_q;
    assign ay_reg   = ay_reg_q;
    assign ay_data  = ay_data_q;
    assign irq      = irq_w;
    assign status   = {overrun_q, (state_q != ST_IDLE), irq_w, en_w};

endmodule

// File: tb/tb_gx4000_dma_sound_sequencer.sv
// Bench for the GX4000 sound DMA sequencer: a memory model and an AY model
// answer the DUT handshakes and compare each request against scoreboard
// queues filled by the stimulus before every scanline tick.
module tb_gx4000_dma_sound_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        plus_mode = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data = 8'h00;
    logic        cpu_wr = 1'b0;
    logic        hsync_tick = 1'b0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic        ay_wr;
    logic [3:0]  ay_reg;
    logic [7:0]  ay_data;
    logic        ay_ack = 1'b0;
    logic [2:0]  irq;
    logic [7:0]  status;

    gx4000_dma_sound_sequencer dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .plus_mode  (plus_mode),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_wr     (cpu_wr),
        .hsync_tick (hsync_tick),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .ay_wr      (ay_wr),
        .ay_reg     (ay_reg),
        .ay_data    (ay_data),
        .ay_ack     (ay_ack),
        .irq        (irq),
        .status     (status)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad = 0;
    int n_fetch = 0;
    int n_ay = 0;
    int collisions = 0;
    int mem_delay = 0;
    bit mem_hold = 1'b0;
    bit ay_hold = 1'b0;
    int base_f;
    int base_a;
    int got;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] exp_fetch [$];
    logic [11:0] exp_ay [$];
    logic [11:0] e_ay;
    logic [15:0] t3_seq [8] = '{16'h4200, 16'h4202, 16'h4204, 16'h4202,
                                16'h4204, 16'h4202, 16'h4204, 16'h4206};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] offs, input logic [7:0] d);
        @(negedge clk_sys);
        cpu_addr = {8'h6C, offs};
        cpu_data = d;
        cpu_wr   = 1'b1;
        @(negedge clk_sys);
        cpu_wr   = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    task automatic set_ch(input int ch, input logic [15:0] a, input logic [7:0] p);
        cpu_write(8'(ch * 4 + 0), a[7:0]);
        cpu_write(8'(ch * 4 + 1), a[15:8]);
        cpu_write(8'(ch * 4 + 2), p);
    endtask

    task automatic tick();
        @(negedge clk_sys);
        hsync_tick = 1'b1;
        @(negedge clk_sys);
        hsync_tick = 1'b0;
    endtask

    // Waits for two consecutive non-busy samples so a one-cycle IDLE between rounds is not taken as the end
    task automatic wait_idle();
        int idle_run;
        int n;
        idle_run = 0;
        n = 0;
        repeat (2) @(negedge clk_sys);
        while (idle_run < 2 && n < 500) begin
            @(negedge clk_sys);
            n++;
            if (status[6] == 1'b0) idle_run++;
            else idle_run = 0;
        end
        check("round_ends", 32'(status[6]), 32'd0);
    endtask

    // Memory model: checks each fetch address against the scoreboard, then acks
    initial begin
        forever begin
            @(negedge clk_sys);
            if (mem_rd === 1'b1) begin
                n_fetch++;
                check("fetch_expected", 32'(exp_fetch.size() != 0), 32'd1);
                if (exp_fetch.size() != 0) check("fetch_addr", 32'(mem_addr), 32'(exp_fetch.pop_front()));
                repeat (mem_delay) @(negedge clk_sys);
                while (mem_hold && mem_rd === 1'b1) @(negedge clk_sys);
                if (mem_rd === 1'b1) begin
                    mem_data = mem.exists(mem_addr) ? mem[mem_addr] : 16'h3000;
                    mem_ack  = 1'b1;
                    @(negedge clk_sys);
                    mem_ack  = 1'b0;
                end
            end
        end
    end

    // AY model: checks register and data against the scoreboard, then acks
    initial begin
        forever begin
            @(negedge clk_sys);
            if (ay_wr === 1'b1) begin
                n_ay++;
                check("ay_expected", 32'(exp_ay.size() != 0), 32'd1);
                if (exp_ay.size() != 0) begin
                    e_ay = exp_ay.pop_front();
                    check("ay_reg", 32'(ay_reg), 32'(e_ay[11:8]));
                    check("ay_data", 32'(ay_data), 32'(e_ay[7:0]));
                end
                while (ay_hold && ay_wr === 1'b1) @(negedge clk_sys);
                if (ay_wr === 1'b1) begin
                    ay_ack = 1'b1;
                    @(negedge clk_sys);
                    ay_ack = 1'b0;
                end
            end
        end
    end

    always @(negedge clk_sys) begin
        if (mem_rd === 1'b1 && ay_wr === 1'b1) collisions++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check("rst_status", 32'(status), 32'h00);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_ay_wr", 32'(ay_wr), 32'h0);
        check("rst_ay_bus", 32'({ay_reg, ay_data}), 32'h0);

        // LOAD then STOP on channel 0
        mem[16'h4000] = 16'h0708;
        mem[16'h4002] = 16'h4020;
        set_ch(0, 16'h4000, 8'h00);
        cpu_write(8'h0F, 8'h01);
        check("t1_enabled", 32'(status), 32'h01);
        exp_fetch.push_back(16'h4000);
        exp_ay.push_back({4'h7, 8'h08});
        tick();
        wait_idle();
        check("t1_fetches", 32'(n_fetch), 32'd1);
        check("t1_ay_writes", 32'(n_ay), 32'd1);
        exp_fetch.push_back(16'h4002);
        tick();
        wait_idle();
        check("t1_fetches_2", 32'(n_fetch), 32'd2);
        check("t1_status", 32'(status), 32'h00);

        // PAUSE 3 with prescaler 1: LOAD lands on tick 8
        mem[16'h4100] = 16'h1003;
        mem[16'h4102] = 16'h0100;
        mem[16'h4104] = 16'h4020;
        set_ch(0, 16'h4100, 8'h01);
        cpu_write(8'h0F, 8'h01);
        base_f = n_fetch;
        base_a = n_ay;
        exp_fetch.push_back(16'h4100);
        tick();
        wait_idle();
        for (int t = 2; t <= 7; t++) begin
            tick();
            wait_idle();
        end
        check("t2_no_fetch_paused", 32'(n_fetch), 32'(base_f + 1));
        check("t2_no_ay_before_8", 32'(n_ay), 32'(base_a));
        exp_fetch.push_back(16'h4102);
        exp_ay.push_back({4'h1, 8'h00});
        tick();
        wait_idle();
        check("t2_load_tick8", 32'(n_ay), 32'(base_a + 1));
        exp_fetch.push_back(16'h4104);
        tick();
        wait_idle();
        check("t2_status", 32'(status), 32'h00);

        // REPEAT 2 around a LOAD, then INT+STOP on channel 1
        mem[16'h4200] = 16'h2002;
        mem[16'h4202] = 16'h0A55;
        mem[16'h4204] = 16'h4001;
        mem[16'h4206] = 16'h4030;
        set_ch(1, 16'h4200, 8'h00);
        cpu_write(8'h0F, 8'h02);
        base_a = n_ay;
        for (int t = 0; t < 8; t++) begin
            exp_fetch.push_back(t3_seq[t]);
            if (t3_seq[t] == 16'h4202) exp_ay.push_back({4'hA, 8'h55});
            tick();
            wait_idle();
        end
        check("t3_ay_writes", 32'(n_ay), 32'(base_a + 3));
        check("t3_irq", 32'(irq), 32'b010);
        check("t3_status", 32'(status), 32'h10);
        cpu_write(8'h0F, 8'h20);
        check("t3_irq_cleared", 32'(irq), 32'h0);

        // All three channels, slow memory: order 0,1,2 and no port overlap
        mem_delay = 3;
        mem[16'h4300] = 16'h0111;
        mem[16'h4302] = 16'h4020;
        mem[16'h4400] = 16'h0222;
        mem[16'h4402] = 16'h4020;
        mem[16'h4500] = 16'h0333;
        mem[16'h4502] = 16'h4020;
        set_ch(0, 16'h4300, 8'h00);
        set_ch(1, 16'h4400, 8'h00);
        set_ch(2, 16'h4500, 8'h00);
        cpu_write(8'h0F, 8'h07);
        check("t4_enabled", 32'(status), 32'h07);
        exp_fetch.push_back(16'h4300);
        exp_fetch.push_back(16'h4400);
        exp_fetch.push_back(16'h4500);
        exp_ay.push_back({4'h1, 8'h11});
        exp_ay.push_back({4'h2, 8'h22});
        exp_ay.push_back({4'h3, 8'h33});
        tick();
        wait_idle();
        check("t4_fetch_q_drained", 32'(exp_fetch.size()), 32'd0);
        exp_fetch.push_back(16'h4302);
        exp_fetch.push_back(16'h4402);
        exp_fetch.push_back(16'h4502);
        tick();
        wait_idle();
        check("t4_status", 32'(status), 32'h00);
        check("t4_no_overlap", 32'(collisions), 32'd0);
        mem_delay = 0;

        // Ticks while stalled on ay_ack raise overrun
        mem[16'h4600] = 16'h0444;
        mem[16'h4602] = 16'h4020;
        ay_hold = 1'b1;
        set_ch(0, 16'h4600, 8'h00);
        cpu_write(8'h0F, 8'h01);
        exp_fetch.push_back(16'h4600);
        exp_ay.push_back({4'h4, 8'h44});
        tick();
        got = 0;
        for (int n = 0; n < 50 && got == 0; n++) begin
            @(negedge clk_sys);
            if (ay_wr === 1'b1) got = 1;
        end
        check("t5_ay_stalled", 32'(ay_wr), 32'd1);
        tick();
        tick();
        check("t5_overrun", 32'(status[7]), 32'd1);
        exp_fetch.push_back(16'h4602);
        ay_hold = 1'b0;
        wait_idle();
        check("t5_status", 32'(status), 32'h80);

        // Reset while a fetch is outstanding
        mem_hold = 1'b1;
        set_ch(0, 16'h4700, 8'h00);
        cpu_write(8'h0F, 8'h01);
        exp_fetch.push_back(16'h4700);
        tick();
        got = 0;
        for (int n = 0; n < 50 && got == 0; n++) begin
            @(negedge clk_sys);
            if (mem_rd === 1'b1) got = 1;
        end
        check("t5_mem_rd_held", 32'(mem_rd), 32'd1);
        @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        check("t5_rst_mem_rd", 32'(mem_rd), 32'd0);
        check("t5_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("t5_rst_ay", 32'({ay_wr, ay_reg, ay_data}), 32'd0);
        check("t5_rst_status", 32'(status), 32'h00);
        check("t5_rst_irq", 32'(irq), 32'h0);
        mem_hold = 1'b0;

        // Address wrap from 0xFFFE to 0x0000 on channel 2
        mem[16'hFFFE] = 16'h0000;
        mem[16'h0000] = 16'h4020;
        set_ch(2, 16'hFFFE, 8'h00);
        cpu_write(8'h0F, 8'h04);
        exp_fetch.push_back(16'hFFFE);
        exp_ay.push_back({4'h0, 8'h00});
        tick();
        wait_idle();
        exp_fetch.push_back(16'h0000);
        tick();
        wait_idle();
        check("t6_status", 32'(status), 32'h00);

        // CPU addr-low write in the EXEC cycle beats the FSM pointer advance
        mem[16'h5000] = 16'h3000;
        mem[16'h5020] = 16'h4020;
        set_ch(0, 16'h5000, 8'h00);
        cpu_write(8'h0F, 8'h01);
        exp_fetch.push_back(16'h5000);
        tick();
        got = 0;
        for (int n = 0; n < 50 && got == 0; n++) begin
            @(posedge clk_sys);
            if (mem_ack === 1'b1) got = 1;
        end
        check("t7_fetch_acked", 32'(got), 32'd1);
        cpu_write(8'h00, 8'h20);
        wait_idle();
        exp_fetch.push_back(16'h5020);
        tick();
        wait_idle();
        check("t7_status", 32'(status), 32'h00);

        check("end_fetch_q_empty", 32'(exp_fetch.size()), 32'd0);
        check("end_ay_q_empty", 32'(exp_ay.size()), 32'd0);
        check("end_no_overlap", 32'(collisions), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gx4000_dma_sound_sequencer.md
Name: gx4000_dma_sound_sequencer

Overview:
- Plus-mode sound DMA controller: three channels execute sound lists from ASIC-mapped memory, one instruction per enabled channel per scanline.
- Sequences AY-3-8912 register writes, pauses, repeats and interrupts.
- Arbitrates the shared memory-read port and the shared AY write port between the channels in fixed order 0, 1, 2.
- Sits between the CPU register bus and the audio mixer/PSG in the GX4000 audio path.

Parameters:
- NUM_CH, 3, number of DMA channels (fixed at 3; register map assumes 3).
- REG_PAGE, 8'h6C, cpu_addr[15:8] value that selects the DMA register page.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- plus_mode  in  1  1 = Plus features active; 0 = ticks ignored
- cpu_addr  in  16  CPU address
- cpu_data  in  8  CPU write data
- cpu_wr  in  1  CPU write strobe, one cycle
- hsync_tick  in  1  one-cycle pulse per scanline
- mem_rd  out  1  instruction fetch request
- mem_addr  out  16  fetch word address, bit0 = 0
- mem_ack  in  1  fetch complete; mem_data valid this cycle
- mem_data  in  16  instruction word
- ay_wr  out  1  AY register write request
- ay_reg  out  4  AY register index
- ay_data  out  8  AY write data
- ay_ack  in  1  AY write accepted
- irq  out  3  per-channel interrupt flags, sticky
- status  out  8  {overrun, busy, irq[2:0], enable[2:0]}

Behaviour:
- Reset (reset_n=0 at an edge): every output is 0. All channel registers are 0. FSM goes to IDLE; pending and overrun clear. Any in-flight handshake is abandoned, so mem_rd and ay_wr drop after that edge.
- Register map (cpu_wr with cpu_addr[15:8]==REG_PAGE), offset = cpu_addr[7:0]:
  - ch*4+0: addr[7:1]; written bit0 ignored.
  - ch*4+1: addr[15:8].
  - ch*4+2: prescaler[7:0].
  - 0x0F DCSR: bits[2:0] write the enables; a 1 in bits[6:4] clears the matching irq.
  - Other offsets: ignored.
- CPU write and FSM update to the same register in the same cycle: the CPU write wins.
- Per-channel state: addr[15:0], prescaler[7:0], presc_cnt[7:0], pause_cnt[11:0], loop_cnt[11:0], loop_addr[15:0], enable.
- Tick handling: a hsync_tick with plus_mode=1 sets pending. A tick that arrives while pending is already set sets sticky overrun; overrun is cleared only by reset.
- FSM states: IDLE, CHK, FETCH, EXEC, AYWR, NEXT.
  - IDLE: if pending, clear pending, ch=0, go to CHK.
  - CHK, channel disabled: go to NEXT.
  - CHK, pause_cnt!=0: if presc_cnt==0, load presc_cnt=prescaler and decrement pause_cnt; otherwise decrement presc_cnt. Go to NEXT.
  - CHK, otherwise: go to FETCH with mem_rd=1 and mem_addr=addr.
  - FETCH: hold mem_rd and mem_addr until mem_ack. Latch mem_data, drop mem_rd, go to EXEC.
  - EXEC: decode the latched word. Next addr = addr+2, wrapping 16'hFFFE->16'h0000, unless LOOP is taken.
  - AYWR: hold ay_wr, ay_reg and ay_data until ay_ack, then drop ay_wr and go to NEXT.
  - NEXT: if ch==2 go to IDLE, else ch+1 and go to CHK.
- Latency: a tick sampled at edge 0 gives CHK at edge 1 and mem_rd high after edge 2.
- Opcodes, selected by word[15:12]:
  - 0 LOAD: ay_reg=word[11:8], ay_data=word[7:0], ay_wr=1, go to AYWR.
  - 1 PAUSE: pause_cnt=word[11:0], presc_cnt=prescaler; n=0 behaves as NOP.
  - 2 REPEAT: loop_cnt=word[11:0], loop_addr=addr+2.
  - 4 CTRL: bit0 LOOP, bit4 INT, bit5 STOP; all set bits act in the same cycle.
    - LOOP: if loop_cnt!=0, decrement loop_cnt and set addr=loop_addr.
    - INT: set irq[ch].
    - STOP: clear enable[ch].
  - Other values: NOP.
- Opcodes other than LOAD go from EXEC to NEXT.
- Enable cleared by the CPU mid-instruction: the current handshake completes, and the channel is skipped from the next CHK on.
- plus_mode falling mid-round: the round completes. Later ticks do not set pending.
- irq clear and INT set for the same channel in the same cycle: set wins.

Decomposition:
- Package gx4000_dma_pkg holds:
  - FSM state enum.
  - Opcode constants OP_LOAD=4'h0, OP_PAUSE=4'h1, OP_REPEAT=4'h2, OP_CTRL=4'h4.
  - CTRL bit positions.
  - Register offsets and DCSR bit fields.
- Sub-module gx4000_dma_chan holds the per-channel register file and pause/prescale/loop counters; it is instanced NUM_CH times. The top level contains the FSM, arbitration and the CPU decode.

Test Plan:
- Ch0 addr=0x4000, list [0x0708, 0x4020], enable=001, one tick → single mem_rd at 0x4000, then ay_wr reg 7 data 0x08, then fetch at 0x4002. Result: enable[0]=0, status=0x00.
- Ch0 [0x1003, 0x0100], prescaler=1, repeated ticks → the LOAD of reg 1 executes on tick 8 (pause 3 × prescale 2, plus the fetch tick).
- Ch1 [0x2002, 0x0A55, 0x4001, 0x4030] → exactly three ay_wr of reg 10 data 0x55, then irq[1]=1 and stop. A DCSR write of 0x20 clears irq[1].
- All three channels enabled, mem_ack delayed 3 cycles → fetch order is ch0, ch1, ch2 per tick, and mem_rd and ay_wr are never asserted together.
- Second hsync_tick while a round is stalled on ay_ack → status[7] overrun=1. Then reset_n=0 for one edge with mem_rd high → all outputs 0 on the next cycle.
- Ch2 addr set to 0xFFFE with list word 0x0000 → the next fetch is at 0x0000. A same-cycle CPU write to addr-low wins over the FSM's addr+2.
